// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART 8N1 transmit serializer with valid/ready byte input
//
// Accepts one byte per frame over a valid/ready handshake and shifts it out
// LSB first as start bit, 8 data bits, optional even parity bit, stop bit.
// Each serial bit lasts CLK_DIV clock cycles.
//
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// between the last data bit and the stop bit (11-bit frame).
//
// Parameters:
//   CLK_DIV   clock cycles per serial bit, must be >= 2
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_valid  byte on tx_byte is offered
//   tx_byte   parallel byte to send
//   tx_ready  block can accept a byte (high only when idle)
//   tx_data   registered serial line, idle high
//   tx_busy   frame in progress (inverse of tx_ready)
//   tx_done   one-cycle pulse in the last cycle of the stop bit

module uart_tx_serializer #(
  parameter int CLK_DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_byte,
  output logic       tx_ready,
  output logic       tx_data,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             data_q, data_d;
  logic             bit_end;
`ifdef UART_TX_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers; tx_data resets high so an abandoned frame releases
  // the line immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      data_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      data_q   <= data_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    data_d   = 1'b1;
    tx_ready = 1'b0;
    tx_done  = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Baud counter runs only inside a frame and restarts at every bit boundary.
    if (state_q != S_IDLE) begin
      baud_d = bit_end ? '0 : baud_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        tx_ready = 1'b1;
        baud_d   = '0;
        bit_d    = '0;
        if (tx_valid) begin
          shift_d  = tx_byte;
`ifdef UART_TX_PARITY_EN
          parity_d = ^tx_byte;
`endif
          state_d  = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          tx_done = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The line register follows the state being entered so that each bit
    // appears exactly one cycle after the edge that starts it.
    case (state_d)
      S_START:  data_d = 1'b0;
      S_DATA:   data_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: data_d = parity_d;
`endif
      default:  data_d = 1'b1;
    endcase
  end

  assign tx_data = data_q;
  assign tx_busy = ~tx_ready;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb/tb_uart_tx_serializer.sv - directed self-checking bench for uart_tx_serializer

module tb_uart_tx_serializer;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
  localparam int LOWS_00 = 20;
  localparam int LOWS_FF = 4;
`else
  localparam int FRAME_BITS = 10;
  localparam int LOWS_00 = 18;
  localparam int LOWS_FF = 2;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_byte = 8'h00;
  logic       tx_ready, tx_data, tx_busy, tx_done;
  logic       tx_valid2 = 1'b0;
  logic [7:0] tx_byte2 = 8'h00;
  logic       tx_ready2, tx_data2, tx_busy2, tx_done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_byte(tx_byte),
    .tx_ready(tx_ready), .tx_data(tx_data), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  uart_tx_serializer #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .tx_valid(tx_valid2), .tx_byte(tx_byte2),
    .tx_ready(tx_ready2), .tx_data(tx_data2), .tx_busy(tx_busy2), .tx_done(tx_done2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int sel, input logic v, input logic [7:0] b);
    if (sel != 0) begin
      tx_valid2 = v;
      tx_byte2  = b;
    end else begin
      tx_valid = v;
      tx_byte  = b;
    end
  endtask

  // Expected line level in cycle T+i of a frame accepted at T.
  function automatic logic exp_line(input logic [7:0] b, input int i, input int d);
    int slot;
    slot = (i - 1) / d;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Sends one byte from idle, checks every cycle of the frame plus three idle
  // cycles, optionally pulsing tx_valid with another byte at cycle glitch_at.
  task automatic run_frame(input int sel, input logic [7:0] b, input int glitch_at,
                           input logic [7:0] gbyte, output int lows, output logic par);
    int d;
    int n;
    int dc;
    int slot;
    logic [7:0] dec;
    logic obs_data, obs_done, obs_ready, obs_busy;
    d = (sel != 0) ? 2 : 4;
    n = FRAME_BITS * d;
    dc = 0;
    lows = 0;
    par = 1'b0;
    dec = 8'h00;
    check("idle_ready", 32'((sel != 0) ? tx_ready2 : tx_ready), 32'd1);
    drive(sel, 1'b1, b);
    for (int i = 1; i <= n + 3; i++) begin
      tick();
      obs_data  = (sel != 0) ? tx_data2  : tx_data;
      obs_done  = (sel != 0) ? tx_done2  : tx_done;
      obs_ready = (sel != 0) ? tx_ready2 : tx_ready;
      obs_busy  = (sel != 0) ? tx_busy2  : tx_busy;
      check("line", 32'(obs_data), 32'(exp_line(b, i, d)));
      check("done", 32'(obs_done), 32'(i == n));
      check("ready", 32'(obs_ready), 32'(i > n));
      check("busy", 32'(obs_busy), 32'(i <= n));
      if (obs_done) dc++;
      if (i <= n && !obs_data) lows++;
      slot = (i - 1) / d;
      if (((i - 1) % d) == d / 2) begin
        if (slot >= 1 && slot <= 8) dec[slot-1] = obs_data;
        if (slot == 9) par = obs_data;
      end
      if (i == glitch_at) drive(sel, 1'b1, gbyte);
      else drive(sel, 1'b0, ~b);
    end
    check("done_count", 32'(dc), 32'd1);
    check("decoded", 32'(dec), 32'(b));
  endtask

  logic [7:0] seq [3] = '{8'h41, 8'h42, 8'h43};
  logic       line_log [256];
  int         acc [3];

  initial begin
    int lows;
    logic par;
    int na;
    logic pend;
    logic [7:0] dec;
    int base;

    // Reset state
    tick();
    tick();
    check("rst_data", 32'(tx_data), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_data2", 32'(tx_data2), 32'd1);
    check("rst_ready2", 32'(tx_ready2), 32'd1);
    rst = 1'b0;
    tick();

    // Single 0x41 frame: start, 1,0,0,0,0,0,1,0, stop
    run_frame(0, 8'h41, 0, 8'h00, lows, par);
    check("lows_41", 32'(lows), 32'(4 * (1 + 6)));

`ifdef UART_TX_PARITY_EN
    run_frame(0, 8'h43, 0, 8'h00, lows, par);
    check("parity_43", 32'(par), 32'd1);
    run_frame(0, 8'h41, 0, 8'h00, lows, par);
    check("parity_41", 32'(par), 32'd0);
`endif

    // tx_valid held high; sequencer advances the byte after each accept
    na = 0;
    pend = 1'b0;
    drive(0, 1'b1, seq[0]);
    for (int c = 0; c < 3 * FRAME_BITS * 4 + 10; c++) begin
      if (c != 0) tick();
      if (pend) begin
        pend = 1'b0;
        if (na < 3) drive(0, 1'b1, seq[na]);
        else drive(0, 1'b0, 8'hEE);
      end
      line_log[c] = tx_data;
      if (tx_ready && tx_valid && na < 3) begin
        acc[na] = c;
        na++;
        pend = 1'b1;
      end
    end
    check("hold_accepts", 32'(na), 32'd3);
    if (na == 3) begin
      check("spacing_1", 32'(acc[1] - acc[0]), 32'(FRAME_BITS * 4 + 1));
      check("spacing_2", 32'(acc[2] - acc[1]), 32'(FRAME_BITS * 4 + 1));
      for (int f = 0; f < 3; f++) begin
        base = acc[f];
        check("hold_start", 32'(line_log[base + 3]), 32'd0);
        for (int k = 0; k < 8; k++) dec[k] = line_log[base + (k + 1) * 4 + 3];
        check("hold_byte", 32'(dec), 32'(seq[f]));
        check("hold_stop", 32'(line_log[base + (FRAME_BITS - 1) * 4 + 3]), 32'd1);
      end
    end
    tick();

    // 0x55 offered during DATA of 0x41 is dropped
    run_frame(0, 8'h41, 15, 8'h55, lows, par);
    tick();
    check("no_queue", 32'(tx_ready), 32'd1);

    // Reset during data bit 3 of 0x42, then 0xA5
    drive(0, 1'b1, 8'h42);
    for (int i = 1; i <= 18; i++) begin
      tick();
      drive(0, 1'b0, 8'h42);
    end
    check("pre_rst_line", 32'(tx_data), 32'd0);
    check("pre_rst_busy", 32'(tx_busy), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_line", 32'(tx_data), 32'd1);
    check("mid_rst_busy", 32'(tx_busy), 32'd0);
    check("mid_rst_done", 32'(tx_done), 32'd0);
    tick();
    check("in_rst_done", 32'(tx_done), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_done", 32'(tx_done), 32'd0);
      check("post_rst_line", 32'(tx_data), 32'd1);
    end
    run_frame(0, 8'hA5, 0, 8'h00, lows, par);

    // CLK_DIV = 2 extremes
    run_frame(1, 8'h00, 0, 8'h00, lows, par);
    check("lows_00", 32'(lows), 32'(LOWS_00));
    run_frame(1, 8'hFF, 0, 8'h00, lows, par);
    check("lows_ff", 32'(lows), 32'(LOWS_FF));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx_serializer.md
# uart_tx_serializer

- UART transmit serializer for the UART verification environment: accepts parallel bytes over a valid/ready handshake and drives an 8N1 serial line, LSB first.
- Generates the byte stream (e.g. 0x41, 0x42, 0x43) consumed by the receive-side scoreboard.
- Sits between the stimulus/sequencer logic and the serial `tx_data` line.

## Interface
- `CLK_DIV`, default 16: clock cycles per serial bit; legal range ≥ 2.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `tx_valid`  input  1  byte on `tx_byte` is offered for transmission.
- `tx_byte`  input  8  parallel byte to send.
- `tx_ready`  output  1  block can accept a byte; high only in IDLE.
- `tx_data`  output  1  serial line; idle-high, registered.
- `tx_busy`  output  1  high from the cycle after accept until the frame completes.
- `tx_done`  output  1  one-cycle pulse in the last cycle of the stop bit.

## Operation
- Reset values:
  - `tx_data` = 1, `tx_busy` = 0, `tx_done` = 0.
  - State = IDLE, so `tx_ready` = 1.
  - Baud counter = 0, bit counter = 0, shift register = 0.
- States: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- IDLE:
  - `tx_ready` = 1 combinationally.
  - Accept occurs on a rising edge with `tx_valid` & `tx_ready`.
  - On accept, `tx_byte` is captured into the shift register and the state moves to START.
- START: `tx_data` = 0 for `CLK_DIV` cycles.
- DATA:
  - Drives bits 0..7, LSB first, each for `CLK_DIV` cycles.
  - 3-bit bit counter; the shift register shifts right at each bit boundary.
  - After bit 7, go to PARITY if enabled, otherwise STOP.
- STOP:
  - `tx_data` = 1 for `CLK_DIV` cycles.
  - `tx_done` = 1 in the final cycle of the stop bit; the state returns to IDLE on that edge.
- Baud counter:
  - Width `$clog2(CLK_DIV)`.
  - Counts 0..`CLK_DIV`-1, clears at each bit boundary.
  - No wrap between bits.
- `tx_byte` changes after accept are ignored. `tx_valid` while not ready is ignored; the byte is not queued.
- Reset mid-frame: `tx_data` goes high immediately (asynchronously) and the frame is abandoned, with no `tx_done`. After reset release the block is in IDLE.
- `tx_valid` held high continuously: a new byte is accepted on the first IDLE cycle after each frame.

## Timing
- Accept edge at cycle T.
- `tx_data` falls at T+1 (start bit). The start bit covers cycles T+1..T+`CLK_DIV`.
- Data bit k covers T+1+(k+1)·`CLK_DIV` .. T+(k+2)·`CLK_DIV`.
- Frame = 10·`CLK_DIV` cycles (11·`CLK_DIV` with parity).
- `tx_done` is high in cycle T+10·`CLK_DIV` (T+11·`CLK_DIV` with parity).
- `tx_ready` is high again at T+10·`CLK_DIV`+1 (T+11·`CLK_DIV`+1 with parity).
- Back-to-back: minimum accept-to-accept spacing = 10·`CLK_DIV`+1 cycles. The line stays high for one extra idle cycle between frames.
- `tx_busy` = !`tx_ready`.

## Configuration
- `UART_TX_PARITY_EN` defined:
  - PARITY state inserted after DATA.
  - `tx_data` = XOR of the 8 captured data bits (even parity) for `CLK_DIV` cycles.
  - Frame becomes 11 bits.
- `UART_TX_PARITY_EN` undefined: no PARITY state and no parity logic; 10-bit 8N1 frame.

## Test plan
- Reset, `CLK_DIV`=4, parity off:
  - Stimulus: send 0x41 at cycle T.
  - Required: `tx_data` = 0 over T+1..T+4, then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then 1 over T+37..T+40.
  - Required: `tx_done` high only at T+40; `tx_ready` high again at T+41.
- `tx_valid` held high with 0x41, 0x42, 0x43 queued by the sequencer:
  - Required: three frames with accepts spaced exactly 41 cycles apart.
  - Required: the decoded bytes match 0x41, 0x42, 0x43 in order.
- Pulse `tx_valid` with 0x55 during the DATA state of an 0x41 frame:
  - Required: 0x55 is ignored and 0x41 completes unaltered.
  - Required: exactly one `tx_done` pulse.
- Assert `rst` during data bit 3 of 0x42:
  - Required: `tx_data` = 1 and `tx_busy` = 0 immediately; no `tx_done`.
  - Required: after release, 0xA5 transmits correctly.
- Parity on, `CLK_DIV`=4:
  - 0x43 → parity bit 1; 0x41 → parity bit 0.
  - Required: `tx_done` at T+44.
- `CLK_DIV`=2:
  - 0x00 → line low for 18 cycles (start + 8 data bits), then high for 2.
  - 0xFF → low for 2 cycles, then high for 18.
